// File: rtl/otter_hazard_ctrl_if.sv
// Signal bundle between the OTTER pipeline datapath and its hazard/sequencing controller.
// The datapath takes the master view, the controller takes the slave view.
interface otter_hazard_ctrl_if #(
    parameter int XLEN = 32
);
    logic [4:0]      ID_RS1;
    logic [4:0]      ID_RS2;
    logic            ID_USES_RS1;
    logic            ID_USES_RS2;
    logic            ID_VALID;
    logic [XLEN-1:0] ID_PC;
    logic [4:0]      EX_RS1;
    logic [4:0]      EX_RS2;
    logic [4:0]      EX_RD;
    logic            EX_REGWRITE;
    logic            EX_MEMREAD;
    logic            EX_BR_TAKEN;
    logic            EX_MRET;
    logic [4:0]      MEM_RD;
    logic            MEM_REGWRITE;
    logic [4:0]      WB_RD;
    logic            WB_REGWRITE;
    logic            INTR;
    logic            MIE;

    logic            PC_WRITE;
    logic            IMEM_RDEN;
    logic            IF_ID_WRITE;
    logic            IF_ID_FLUSH;
    logic            ID_EX_FLUSH;
    logic [1:0]      PC_SEL;
    logic [1:0]      FWD_A;
    logic [1:0]      FWD_B;
    logic            ID_FWD_A;
    logic            ID_FWD_B;
    logic            INT_TAKEN;
    logic [XLEN-1:0] INT_EPC;
    logic [1:0]      DBG_STATE;

    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_VALID, ID_PC,
        output EX_RS1, EX_RS2, EX_RD, EX_REGWRITE, EX_MEMREAD, EX_BR_TAKEN, EX_MRET,
        output MEM_RD, MEM_REGWRITE, WB_RD, WB_REGWRITE, INTR, MIE,
        input  PC_WRITE, IMEM_RDEN, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL,
        input  FWD_A, FWD_B, ID_FWD_A, ID_FWD_B, INT_TAKEN, INT_EPC, DBG_STATE
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, ID_VALID, ID_PC,
        input  EX_RS1, EX_RS2, EX_RD, EX_REGWRITE, EX_MEMREAD, EX_BR_TAKEN, EX_MRET,
        input  MEM_RD, MEM_REGWRITE, WB_RD, WB_REGWRITE, INTR, MIE,
        output PC_WRITE, IMEM_RDEN, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PC_SEL,
        output FWD_A, FWD_B, ID_FWD_A, ID_FWD_B, INT_TAKEN, INT_EPC, DBG_STATE
    );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage pipeline controller: forwarding selects, load-use stall, redirect flushes
// and the interrupt entry sequence (RUN -> DRAIN x2 -> ENTER).
module otter_hazard_ctrl (
    input logic               CLK,
    input logic               RST,
    otter_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENTER = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       epc_load;
    logic       luh, redirect, intr_ok;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, int_taken;
    logic [1:0] pc_sel, fwd_a, fwd_b;
    logic       id_fwd_a, id_fwd_b;
    logic       unused_inputs;

    // The EX write-enable is not needed: a load always writes, and EX_MEMREAD covers it.
    assign unused_inputs = hz.EX_REGWRITE;

    function automatic logic [1:0] ex_fwd(input logic [4:0] rs, input logic [4:0] mem_rd,
                                          input logic mem_we, input logic [4:0] wb_rd,
                                          input logic wb_we);
        if (mem_we && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
        if (wb_we && wb_rd != 5'd0 && wb_rd == rs)    return 2'b10;
        return 2'b00;
    endfunction

    assign luh = hz.EX_MEMREAD && hz.EX_RD != 5'd0 &&
                 ((hz.ID_USES_RS1 && hz.EX_RD == hz.ID_RS1) ||
                  (hz.ID_USES_RS2 && hz.EX_RD == hz.ID_RS2));
    assign redirect = hz.EX_BR_TAKEN || hz.EX_MRET;
    assign intr_ok  = hz.INTR && hz.MIE && hz.ID_VALID;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            cnt        <= 2'd0;
            hz.INT_EPC <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (epc_load) hz.INT_EPC <= hz.ID_PC;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        epc_load    = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = 2'd0;
        int_taken   = 1'b0;
        fwd_a    = ex_fwd(hz.EX_RS1, hz.MEM_RD, hz.MEM_REGWRITE, hz.WB_RD, hz.WB_REGWRITE);
        fwd_b    = ex_fwd(hz.EX_RS2, hz.MEM_RD, hz.MEM_REGWRITE, hz.WB_RD, hz.WB_REGWRITE);
        id_fwd_a = hz.WB_REGWRITE && hz.WB_RD != 5'd0 && hz.WB_RD == hz.ID_RS1;
        id_fwd_b = hz.WB_REGWRITE && hz.WB_RD != 5'd0 && hz.WB_RD == hz.ID_RS2;

        case (state)
            RUN: begin
                if (redirect) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    pc_sel      = hz.EX_MRET ? 2'd3 : 2'd1;
                end else if (luh) begin
                    id_ex_flush = 1'b1;
                end else if (intr_ok) begin
                    epc_load    = 1'b1;
                    cnt_nxt     = 2'd2;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nxt   = DRAIN;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end
            end
            DRAIN: begin
                // Older instructions keep moving through EX/MEM/WB while fetch is frozen.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                cnt_nxt     = cnt - 2'd1;
                if (cnt == 2'd1) state_nxt = ENTER;
            end
            ENTER: begin
                int_taken   = 1'b1;
                pc_sel      = 2'd2;
                pc_write    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = RUN;
            end
            default: state_nxt = RUN;
        endcase

        if (RST) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_sel      = 2'd0;
            int_taken   = 1'b0;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
            id_fwd_a    = 1'b0;
            id_fwd_b    = 1'b0;
        end
    end

    assign hz.PC_WRITE    = pc_write;
    assign hz.IMEM_RDEN   = pc_write;
    assign hz.IF_ID_WRITE = if_id_write;
    assign hz.IF_ID_FLUSH = if_id_flush;
    assign hz.ID_EX_FLUSH = id_ex_flush;
    assign hz.PC_SEL      = pc_sel;
    assign hz.FWD_A       = fwd_a;
    assign hz.FWD_B       = fwd_b;
    assign hz.ID_FWD_A    = id_fwd_a;
    assign hz.ID_FWD_B    = id_fwd_b;
    assign hz.INT_TAKEN   = int_taken;
    assign hz.DBG_STATE   = state;
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed and random stimulus for otter_hazard_ctrl, checked against a cycle-count model
// of the pipeline control rules and a queue of expected MEPC values.
module tb_otter_hazard_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    otter_hazard_ctrl_if #(.XLEN(32)) hz ();
    otter_hazard_ctrl dut (.CLK(CLK), .RST(RST), .hz(hz.slave));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    // Model: cycles elapsed since interrupt recognition (0 = running normally).
    int          m_phase = 0;
    logic [31:0] m_epc = '0;
    logic        m_redirect, m_luh;
    logic        e_pc_write, e_ifid_write, e_ifid_flush, e_idex_flush, e_int_taken;
    logic [1:0]  e_pc_sel, e_fwd_a, e_fwd_b;
    logic        e_idfwd_a, e_idfwd_b;
    logic        care_ifid_write, care_ifid_flush, care_pc_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (hz.MEM_REGWRITE && hz.MEM_RD != 0 && hz.MEM_RD == rs) return 2'b01;
        if (hz.WB_REGWRITE && hz.WB_RD != 0 && hz.WB_RD == rs)    return 2'b10;
        return 2'b00;
    endfunction

    task automatic compute_expected();
        m_luh = hz.EX_MEMREAD && hz.EX_RD != 0 &&
                ((hz.ID_USES_RS1 && hz.EX_RD == hz.ID_RS1) ||
                 (hz.ID_USES_RS2 && hz.EX_RD == hz.ID_RS2));
        m_redirect = hz.EX_BR_TAKEN || hz.EX_MRET;
        care_ifid_write = 1; care_ifid_flush = 1; care_pc_sel = 1;
        e_pc_write = 0; e_ifid_write = 0; e_ifid_flush = 0; e_idex_flush = 0;
        e_int_taken = 0; e_pc_sel = 0;
        e_fwd_a = m_fwd(hz.EX_RS1);
        e_fwd_b = m_fwd(hz.EX_RS2);
        e_idfwd_a = hz.WB_REGWRITE && hz.WB_RD != 0 && hz.WB_RD == hz.ID_RS1;
        e_idfwd_b = hz.WB_REGWRITE && hz.WB_RD != 0 && hz.WB_RD == hz.ID_RS2;
        if (RST) begin
            m_phase = 0; m_epc = '0;
            e_ifid_flush = 1; e_idex_flush = 1;
            e_fwd_a = 0; e_fwd_b = 0; e_idfwd_a = 0; e_idfwd_b = 0;
        end else if (m_phase == 1 || m_phase == 2) begin
            e_ifid_flush = 1; e_idex_flush = 1; care_ifid_write = 0; care_pc_sel = 0;
        end else if (m_phase == 3) begin
            e_int_taken = 1; e_pc_sel = 2; e_pc_write = 1;
            e_ifid_flush = 1; e_idex_flush = 1; care_ifid_write = 0;
            exp_q.push_back(m_epc);
        end else if (m_redirect) begin
            e_pc_write = 1; e_pc_sel = hz.EX_MRET ? 2'd3 : 2'd1;
            e_ifid_flush = 1; e_idex_flush = 1; care_ifid_write = 0;
        end else if (m_luh) begin
            e_idex_flush = 1; care_ifid_flush = 0; care_pc_sel = 0;
        end else if (hz.INTR && hz.MIE && hz.ID_VALID) begin
            e_ifid_flush = 1; e_idex_flush = 1; care_ifid_write = 0; care_pc_sel = 0;
        end else begin
            e_pc_write = 1; e_ifid_write = 1;
        end
    endtask

    task automatic compare_all();
        check("pc_write", hz.PC_WRITE, e_pc_write);
        check("imem_rden", hz.IMEM_RDEN, e_pc_write);
        if (care_ifid_write) check("if_id_write", hz.IF_ID_WRITE, e_ifid_write);
        if (care_ifid_flush) check("if_id_flush", hz.IF_ID_FLUSH, e_ifid_flush);
        check("id_ex_flush", hz.ID_EX_FLUSH, e_idex_flush);
        if (care_pc_sel) check("pc_sel", hz.PC_SEL, e_pc_sel);
        check("fwd_a", hz.FWD_A, e_fwd_a);
        check("fwd_b", hz.FWD_B, e_fwd_b);
        check("id_fwd_a", hz.ID_FWD_A, e_idfwd_a);
        check("id_fwd_b", hz.ID_FWD_B, e_idfwd_b);
        check("int_taken", hz.INT_TAKEN, e_int_taken);
        check("int_epc", hz.INT_EPC, m_epc);
        if (hz.INT_TAKEN === 1'b1) begin
            if (exp_q.size() == 0) check("int_taken_unexpected", hz.INT_TAKEN, 32'd0);
            else check("int_epc_sb", hz.INT_EPC, exp_q.pop_front());
        end
    endtask

    task automatic model_clock();
        if (RST) begin
            m_phase = 0; m_epc = '0;
        end else if (m_phase == 0) begin
            if (!m_redirect && !m_luh && hz.INTR && hz.MIE && hz.ID_VALID) begin
                m_phase = 1; m_epc = hz.ID_PC;
            end
        end else if (m_phase == 3) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
    endtask

    task automatic settle();
        #1;
        compute_expected();
        compare_all();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_clock();
        @(negedge CLK);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        hz.ID_RS1 = 0; hz.ID_RS2 = 0; hz.ID_USES_RS1 = 0; hz.ID_USES_RS2 = 0;
        hz.ID_VALID = 0; hz.ID_PC = '0;
        hz.EX_RS1 = 0; hz.EX_RS2 = 0; hz.EX_RD = 0; hz.EX_REGWRITE = 0;
        hz.EX_MEMREAD = 0; hz.EX_BR_TAKEN = 0; hz.EX_MRET = 0;
        hz.MEM_RD = 0; hz.MEM_REGWRITE = 0; hz.WB_RD = 0; hz.WB_REGWRITE = 0;
        hz.INTR = 0; hz.MIE = 0;
    endtask

    task automatic start_interrupt(input logic [31:0] pc);
        idle();
        hz.INTR = 1; hz.MIE = 1; hz.ID_VALID = 1; hz.ID_PC = pc;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        @(negedge CLK);

        // Reset values
        settle();
        check("rst_pc_write", hz.PC_WRITE, 32'd0);
        check("rst_flush", hz.IF_ID_FLUSH, 32'd1);
        check("rst_epc", hz.INT_EPC, 32'd0);
        tick();
        RST = 1'b0;
        hz.ID_VALID = 1; hz.ID_PC = 32'h100;
        step();

        // lw x5 in EX, add x6,x5,x1 in ID
        idle();
        hz.EX_MEMREAD = 1; hz.EX_REGWRITE = 1; hz.EX_RD = 5;
        hz.ID_RS1 = 5; hz.ID_RS2 = 1; hz.ID_USES_RS1 = 1; hz.ID_USES_RS2 = 1; hz.ID_VALID = 1;
        settle();
        check("luh_pc_write", hz.PC_WRITE, 32'd0);
        check("luh_ifid_write", hz.IF_ID_WRITE, 32'd0);
        check("luh_idex_flush", hz.ID_EX_FLUSH, 32'd1);
        tick();
        idle();
        hz.MEM_RD = 5; hz.MEM_REGWRITE = 1;
        hz.ID_RS1 = 5; hz.ID_RS2 = 1; hz.ID_USES_RS1 = 1; hz.ID_USES_RS2 = 1; hz.ID_VALID = 1;
        step();
        idle();
        hz.EX_RS1 = 5; hz.EX_RS2 = 1; hz.WB_RD = 5; hz.WB_REGWRITE = 1;
        settle();
        check("load_fwd_a", hz.FWD_A, 32'd2);
        tick();

        // add x3 in MEM, sub x4,x3,x3 in EX
        idle();
        hz.EX_RS1 = 3; hz.EX_RS2 = 3; hz.MEM_RD = 3; hz.MEM_REGWRITE = 1;
        hz.WB_RD = 3; hz.WB_REGWRITE = 1;
        settle();
        check("b2b_fwd_a", hz.FWD_A, 32'd1);
        check("b2b_fwd_b", hz.FWD_B, 32'd1);
        tick();
        idle();
        hz.MEM_RD = 0; hz.MEM_REGWRITE = 1; hz.WB_RD = 7; hz.WB_REGWRITE = 1; hz.ID_RS1 = 7;
        settle();
        check("x0_fwd_a", hz.FWD_A, 32'd0);
        check("id_fwd_a_wb", hz.ID_FWD_A, 32'd1);
        tick();

        // Redirect alongside luh and a rising INTR
        idle();
        hz.EX_BR_TAKEN = 1; hz.EX_MEMREAD = 1; hz.EX_RD = 5;
        hz.ID_RS1 = 5; hz.ID_USES_RS1 = 1; hz.ID_VALID = 1; hz.INTR = 1; hz.MIE = 1;
        settle();
        check("redir_pc_sel", hz.PC_SEL, 32'd1);
        check("redir_pc_write", hz.PC_WRITE, 32'd1);
        check("redir_idex_flush", hz.ID_EX_FLUSH, 32'd1);
        tick();
        idle();
        hz.INTR = 1; hz.MIE = 1;
        step();

        // mret, then INTR masked
        idle();
        hz.EX_MRET = 1;
        settle();
        check("mret_pc_sel", hz.PC_SEL, 32'd3);
        tick();
        idle();
        hz.INTR = 1; hz.MIE = 0; hz.ID_VALID = 1;
        settle();
        check("masked_pc_write", hz.PC_WRITE, 32'd1);
        tick();

        // Full interrupt entry; INTR stays high, MIE drops during drain
        start_interrupt(32'h0000_0120);
        settle();
        check("recog_pc_write", hz.PC_WRITE, 32'd0);
        tick();
        idle();
        hz.INTR = 1; hz.MIE = 0;
        step();
        step();
        settle();
        check("enter_int_taken", hz.INT_TAKEN, 32'd1);
        check("enter_pc_sel", hz.PC_SEL, 32'd2);
        check("enter_epc", hz.INT_EPC, 32'h0000_0120);
        tick();
        hz.ID_VALID = 1;
        for (int i = 0; i < 4; i++) step();

        // Reset during the second drain cycle
        start_interrupt(32'h0000_0200);
        step();
        idle();
        step();
        RST = 1'b1;
        settle();
        check("abort_int_taken", hz.INT_TAKEN, 32'd0);
        check("abort_pc_write", hz.PC_WRITE, 32'd0);
        check("abort_epc", hz.INT_EPC, 32'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(0, 59) == 0);
            hz.ID_RS1 = 5'($urandom_range(0, 3));
            hz.ID_RS2 = 5'($urandom_range(0, 3));
            hz.ID_USES_RS1 = ($urandom_range(0, 3) != 0);
            hz.ID_USES_RS2 = ($urandom_range(0, 1) == 0);
            hz.ID_VALID = ($urandom_range(0, 3) != 0);
            hz.ID_PC = $urandom & 32'hFFFF_FFFC;
            hz.EX_RS1 = 5'($urandom_range(0, 3));
            hz.EX_RS2 = 5'($urandom_range(0, 3));
            hz.EX_RD = 5'($urandom_range(0, 3));
            hz.EX_REGWRITE = ($urandom_range(0, 1) == 0);
            hz.EX_MEMREAD = ($urandom_range(0, 2) == 0);
            hz.EX_BR_TAKEN = ($urandom_range(0, 7) == 0);
            hz.EX_MRET = ($urandom_range(0, 15) == 0);
            hz.MEM_RD = 5'($urandom_range(0, 3));
            hz.MEM_REGWRITE = ($urandom_range(0, 1) == 0);
            hz.WB_RD = 5'($urandom_range(0, 3));
            hz.WB_REGWRITE = ($urandom_range(0, 1) == 0);
            hz.INTR = ($urandom_range(0, 3) == 0);
            hz.MIE = ($urandom_range(0, 1) == 0);
            step();
        end
        RST = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) step();
        check("epc_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
